// File: rtl/ammo_bank_if.sv
// Bus bundle between the round controller and the ammo bank.
// round_tick is a one-cycle valid strobe with no back-pressure. tick_done marks the registered results as valid one cycle later.
interface ammo_bank_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_AMMO    = 3
);
  localparam int AMMO_W = $clog2(MAX_AMMO + 1);

  logic                          round_tick;
  logic                          new_round;
  logic [3*NUM_PLAYERS-1:0]      action;
  logic [AMMO_W*NUM_PLAYERS-1:0] ammo;
  logic [NUM_PLAYERS-1:0]        fired;
  logic [NUM_PLAYERS-1:0]        dry_fire;
  logic [NUM_PLAYERS-1:0]        wasted_reload;
  logic [NUM_PLAYERS-1:0]        illegal;
  logic [NUM_PLAYERS-1:0]        hit;
  logic                          tick_done;

  modport master (
    output round_tick, new_round, action,
    input  ammo, fired, dry_fire, wasted_reload, illegal, hit, tick_done
  );

  modport slave (
    input  round_tick, new_round, action,
    output ammo, fired, dry_fire, wasted_reload, illegal, hit, tick_done
  );
endinterface

// File: rtl/ammo_bank.sv
// Multi-player saturating ammo tracker and shot resolver.
// Each round tick applies one action per player and registers fire, dry-fire, reload and hit pulses.
module ammo_bank #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_AMMO    = 3,
  parameter int INIT_AMMO   = 1
) (
  input logic        clk,
  input logic        rst,
  ammo_bank_if.slave bus
);
  localparam int AMMO_W = $clog2(MAX_AMMO + 1);
  localparam logic [AMMO_W-1:0]      MAX_A  = AMMO_W'(MAX_AMMO);
  localparam logic [AMMO_W-1:0]      INIT_A = AMMO_W'(INIT_AMMO);
  localparam logic [NUM_PLAYERS-1:0] ONE    = NUM_PLAYERS'(1);

  logic [AMMO_W*NUM_PLAYERS-1:0] ammo_r, ammo_d;
  logic [NUM_PLAYERS-1:0] fired_r, dry_r, waste_r, ill_r, hit_r;
  logic [NUM_PLAYERS-1:0] fire_d, dry_d, waste_d, ill_d, hit_d;
  logic [NUM_PLAYERS-1:0] exposed;
  logic                   done_r;

  // Decode every player's action against its current count; illegal fields behave as block.
  always_comb begin
    ammo_d  = ammo_r;
    fire_d  = '0;
    dry_d   = '0;
    waste_d = '0;
    ill_d   = '0;
    exposed = '0;
    hit_d   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      case (bus.action[3*p +: 3])
        3'b001: begin
        end
        3'b010: begin
          exposed[p] = 1'b1;
          if (ammo_r[AMMO_W*p +: AMMO_W] < MAX_A)
            ammo_d[AMMO_W*p +: AMMO_W] = ammo_r[AMMO_W*p +: AMMO_W] + 1'b1;
          else
            waste_d[p] = 1'b1;
        end
        3'b100: begin
          exposed[p] = 1'b1;
          if (ammo_r[AMMO_W*p +: AMMO_W] != '0) begin
            ammo_d[AMMO_W*p +: AMMO_W] = ammo_r[AMMO_W*p +: AMMO_W] - 1'b1;
            fire_d[p] = 1'b1;
          end else begin
            dry_d[p] = 1'b1;
          end
        end
        default: ill_d[p] = 1'b1;
      endcase
    end
    // Only real shots from other players strike a non-blocking player.
    for (int p = 0; p < NUM_PLAYERS; p++)
      hit_d[p] = exposed[p] && ((fire_d & ~(ONE << p)) != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ammo_r  <= {NUM_PLAYERS{INIT_A}};
      fired_r <= '0;
      dry_r   <= '0;
      waste_r <= '0;
      ill_r   <= '0;
      hit_r   <= '0;
      done_r  <= 1'b0;
    end else if (bus.new_round) begin
      ammo_r  <= {NUM_PLAYERS{INIT_A}};
      fired_r <= '0;
      dry_r   <= '0;
      waste_r <= '0;
      ill_r   <= '0;
      hit_r   <= '0;
      done_r  <= 1'b0;
    end else if (bus.round_tick) begin
      ammo_r  <= ammo_d;
      fired_r <= fire_d;
      dry_r   <= dry_d;
      waste_r <= waste_d;
      ill_r   <= ill_d;
      hit_r   <= hit_d;
      done_r  <= 1'b1;
    end else begin
      fired_r <= '0;
      dry_r   <= '0;
      waste_r <= '0;
      ill_r   <= '0;
      hit_r   <= '0;
      done_r  <= 1'b0;
    end
  end

  assign bus.ammo          = ammo_r;
  assign bus.fired         = fired_r;
  assign bus.dry_fire      = dry_r;
  assign bus.wasted_reload = waste_r;
  assign bus.illegal       = ill_r;
  assign bus.hit           = hit_r;
  assign bus.tick_done     = done_r;
endmodule

// File: tb/tb_ammo_bank.sv
// Directed bench for ammo_bank: a 2-player default instance and a 4-player, MAX_AMMO=5, INIT_AMMO=0 instance.
module tb_ammo_bank;
  localparam int WA = 14;
  localparam int WB = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ammo_bank_if #(.NUM_PLAYERS(2), .MAX_AMMO(3)) bus_a ();
  ammo_bank_if #(.NUM_PLAYERS(4), .MAX_AMMO(5)) bus_b ();

  ammo_bank #(.NUM_PLAYERS(2), .MAX_AMMO(3), .INIT_AMMO(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  ammo_bank #(.NUM_PLAYERS(4), .MAX_AMMO(5), .INIT_AMMO(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [WA-1:0] exp_qa[$];
  logic [WB-1:0] exp_qb[$];
  logic [WA-1:0] exp_a;
  logic [WB-1:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: pop one expected result per presented tick.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_a.tick_done === 1'b1) begin
      if (exp_qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_tick: actual=tick_done required=none");
      end else begin
        exp_a = exp_qa.pop_front();
        check("a_tick", 32'({bus_a.ammo, bus_a.fired, bus_a.dry_fire,
              bus_a.wasted_reload, bus_a.illegal, bus_a.hit}), 32'(exp_a));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus_b.tick_done === 1'b1) begin
      if (exp_qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_tick: actual=tick_done required=none");
      end else begin
        exp_b = exp_qb.pop_front();
        check("b_tick", {bus_b.ammo, bus_b.fired, bus_b.dry_fire,
              bus_b.wasted_reload, bus_b.illegal, bus_b.hit}, exp_b);
      end
    end
  end

  // Drivers: called at a falling edge, return at the next falling edge.
  task automatic tick_a(input logic [5:0] act, input logic [3:0] am,
                        input logic [1:0] f, input logic [1:0] d, input logic [1:0] w,
                        input logic [1:0] il, input logic [1:0] h);
    exp_qa.push_back({am, f, d, w, il, h});
    bus_a.round_tick = 1'b1;
    bus_a.action     = act;
    @(negedge clk);
    bus_a.round_tick = 1'b0;
    bus_a.action     = 6'($urandom_range(0, 63));
  endtask

  task automatic tick_b(input logic [11:0] act, input logic [11:0] am,
                        input logic [3:0] f, input logic [3:0] d, input logic [3:0] w,
                        input logic [3:0] il, input logic [3:0] h);
    exp_qb.push_back({am, f, d, w, il, h});
    bus_b.round_tick = 1'b1;
    bus_b.action     = act;
    @(negedge clk);
    bus_b.round_tick = 1'b0;
    bus_b.action     = 12'($urandom_range(0, 4095));
  endtask

  task automatic idle_a(input string name, input logic [3:0] am);
    bus_a.round_tick = 1'b0;
    bus_a.new_round  = 1'b0;
    @(negedge clk);
    check(name, 32'({bus_a.ammo, bus_a.fired, bus_a.dry_fire, bus_a.wasted_reload,
          bus_a.illegal, bus_a.hit, bus_a.tick_done}), 32'({am, 11'b0}));
  endtask

  task automatic new_round_a();
    bus_a.new_round = 1'b1;
    @(negedge clk);
    bus_a.new_round = 1'b0;
    check("a_new_round", 32'({bus_a.ammo, bus_a.fired, bus_a.hit, bus_a.tick_done}),
          32'({4'b0101, 5'b0}));
  endtask

  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] R = 3'b010;
  localparam logic [2:0] S = 3'b100;

  initial begin
    rst = 1'b1;
    bus_a.round_tick = 1'b0; bus_a.new_round = 1'b0; bus_a.action = '0;
    bus_b.round_tick = 1'b0; bus_b.new_round = 1'b0; bus_b.action = '0;
    repeat (2) @(negedge clk);
    check("a_reset_ammo", 32'(bus_a.ammo), 32'h5);
    check("b_reset_ammo", 32'(bus_b.ammo), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_a.action = 6'($urandom_range(0, 63));
      idle_a("a_idle", 4'b0101);
    end

    // Reload saturation on player 0, then dry fire on player 1.
    tick_a({B, R}, 4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick_a({B, R}, 4'b0111, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick_a({B, R}, 4'b0111, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    tick_a({S, B}, 4'b0011, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    tick_a({S, B}, 4'b0011, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    idle_a("a_after_dry", 4'b0011);
    new_round_a();

    // Hit resolution.
    tick_a({R, S}, 4'b1000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
    new_round_a();
    tick_a({S, S}, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    new_round_a();
    tick_a({B, S}, 4'b0100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);

    // Illegal fields act as block and shield from hits.
    tick_a({S, 3'b110}, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00);
    tick_a({S, 3'b000}, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00);
    tick_a({R, 3'b111}, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);

    // new_round wins over a simultaneous tick.
    bus_a.round_tick = 1'b1;
    bus_a.new_round  = 1'b1;
    bus_a.action     = {S, S};
    @(negedge clk);
    bus_a.round_tick = 1'b0;
    bus_a.new_round  = 1'b0;
    check("a_priority", 32'({bus_a.ammo, bus_a.fired, bus_a.dry_fire, bus_a.wasted_reload,
          bus_a.illegal, bus_a.hit, bus_a.tick_done}), 32'({4'b0101, 11'b0}));

    // A dry-firing player strikes nobody.
    tick_a({B, S}, 4'b0100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tick_a({R, S}, 4'b1000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    tick_a({S, R}, 4'b0101, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
    idle_a("a_final_idle", 4'b0101);

    // Four-player instance.
    tick_b({R, B, B, B}, 12'h200, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_b({R, B, B, B}, 12'h400, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_b({S, R, R, R}, 12'h249, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    tick_b({S, R, B, S}, 12'h088, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1101);

    // Tick in flight, then asynchronous reset between edges.
    bus_b.round_tick = 1'b1;
    bus_b.action     = {R, S, B, R};
    @(posedge clk);
    #1;
    bus_b.round_tick = 1'b0;
    check("b_in_flight", {8'b0, bus_b.ammo, bus_b.fired, bus_b.hit, bus_b.tick_done, 3'b0},
          {8'b0, 12'h249, 4'b0100, 4'b1001, 1'b1, 3'b0});
    rst = 1'b1;
    #1;
    check("b_async_reset", {15'b0, bus_b.ammo, bus_b.fired, bus_b.hit, bus_b.tick_done},
          {15'b0, 12'h000, 4'b0000, 4'b0000, 1'b0});
    check("a_async_reset", 32'(bus_a.ammo), 32'h5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick_b({R, B, B, B}, 12'h200, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_b({B, B, R, S}, 12'h208, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    check("b_queue_drained", 32'(exp_qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
